// File: rtl/asic_host_driver.sv
// asic_host_driver
//   Host-side sequencer for the ASIC top. A one-cycle Start request latches
//   two operands. Each operand is then presented on Inport for HOLD_CYCLES
//   cycles, A first and then B. After that the block waits for a rising edge
//   on Done and captures Outport into Result. If no edge arrives within
//   TIMEOUT_CYCLES cycles, the job is abandoned and TimedOut pulses instead.
//
// Ports
//   CLK          system clock, rising edge
//   RST_N        synchronous active-low reset
//   Start        job request, accepted only while idle
//   OpA, OpB     operands, latched on an accepted Start
//   Busy         high whenever a job is in progress
//   Inport       operand bus driven into the ASIC
//   Outport      ASIC result bus
//   Done         ASIC completion flag (level or pulse; only rising edges count)
//   Result       Outport captured on the last successful job
//   ResultValid  one-cycle pulse when Result updates
//   TimedOut     one-cycle pulse when a job is abandoned
module asic_host_driver #(
  parameter int WIDTH          = 16,
  parameter int HOLD_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             Start,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  output logic             Busy,
  output logic [WIDTH-1:0] Inport,
  input  logic [WIDTH-1:0] Outport,
  input  logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             ResultValid,
  output logic             TimedOut
);

  localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);
  localparam logic [TCW-1:0] TO_LAST   = TCW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DRIVE_A   = 2'd1,
    DRIVE_B   = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [HCW-1:0]   hcnt_q, hcnt_d;
  logic [TCW-1:0]   tcnt_q, tcnt_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] inport_q, inport_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             rv_q, rv_d;
  logic             to_q, to_d;
  logic             done_q;
  logic             done_evt;

  // Only a fresh rising edge completes a job. A Done level left over from an
  // earlier job, or one already high at reset, is never accepted.
  assign done_evt = Done & ~done_q;

  always_comb begin
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    tcnt_d   = tcnt_q;
    op_b_d   = op_b_q;
    inport_d = inport_q;
    result_d = result_q;
    rv_d     = 1'b0;
    to_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (Start) begin
          // A goes straight onto the bus, so only B needs a holding register.
          op_b_d   = OpB;
          inport_d = OpA;
          hcnt_d   = HOLD_LAST;
          state_d  = DRIVE_A;
        end
      end
      DRIVE_A: begin
        if (hcnt_q == '0) begin
          hcnt_d   = HOLD_LAST;
          inport_d = op_b_q;
          state_d  = DRIVE_B;
        end else begin
          hcnt_d = hcnt_q - 1'b1;
        end
      end
      DRIVE_B: begin
        if (hcnt_q == '0) begin
          tcnt_d  = '0;
          state_d = WAIT_DONE;
        end else begin
          hcnt_d = hcnt_q - 1'b1;
        end
      end
      WAIT_DONE: begin
        // Completion is tested first, so it wins over a simultaneous timeout.
        if (done_evt) begin
          result_d = Outport;
          rv_d     = 1'b1;
          state_d  = IDLE;
        end else if (tcnt_q == TO_LAST) begin
          to_d    = 1'b1;
          state_d = IDLE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      hcnt_q   <= '0;
      tcnt_q   <= '0;
      inport_q <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      rv_q     <= 1'b0;
      to_q     <= 1'b0;
      done_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      tcnt_q   <= tcnt_d;
      inport_q <= inport_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      rv_q     <= rv_d;
      to_q     <= to_d;
      done_q   <= Done;
    end
  end

  // The latched operand is only read after a Start has loaded it.
  always_ff @(posedge CLK) begin
    op_b_q <= op_b_d;
  end

  assign Busy        = busy_q;
  assign Inport      = inport_q;
  assign Result      = result_q;
  assign ResultValid = rv_q;
  assign TimedOut    = to_q;

endmodule

// File: doc/asic_host_driver.md
Name: asic_host_driver

Overview:
- Host-side counterpart to the ASIC top. It turns a one-cycle job request (two 16-bit operands) into the timed operand sequence on the ASIC's `Inport`, then waits for the ASIC's `Done` and captures `Outport` as the job result.
- Sits beside the ASIC in the lab top level and the system bench. It replaces hand-driven `Inport` stimulus and gives a bounded wait with a timeout flag.

Parameters:
- `WIDTH`, 16, data width of operands, `Inport`, `Outport` and `Result`.
- `HOLD_CYCLES`, 4, cycles each operand is held on `Inport`; must be at least 1.
- `TIMEOUT_CYCLES`, 64, maximum cycles spent in `WAIT_DONE` before the job is abandoned; must be at least 1.

Ports:
- `CLK`  input  1  system clock; all logic on the rising edge.
- `RST_N`  input  1  synchronous, active-low reset.
- `Start`  input  1  job request; accepted only in `IDLE`.
- `OpA`  input  `WIDTH`  first operand; latched when `Start` is accepted.
- `OpB`  input  `WIDTH`  second operand; latched when `Start` is accepted.
- `Busy`  output  1  high in every state except `IDLE`.
- `Inport`  output  `WIDTH`  operand bus driven into the ASIC.
- `Outport`  input  `WIDTH`  ASIC result bus.
- `Done`  input  1  ASIC completion flag; may be a level or a pulse.
- `Result`  output  `WIDTH`  captured `Outport` value of the last successful job.
- `ResultValid`  output  1  one-cycle pulse when `Result` updates.
- `TimedOut`  output  1  one-cycle pulse when a job is abandoned.

Behaviour:
- All outputs and state are registered.
- Reset applies when `RST_N`=0 at a rising `CLK` edge. Reset values:
  - state `IDLE`;
  - `Inport`=0, `Result`=0;
  - `Busy`=0, `ResultValid`=0, `TimedOut`=0;
  - hold counter and timeout counter 0;
  - `Done` history register `done_q`=1, so a `Done` that is already high after reset is not seen as an edge.
- Reset mid-job aborts the job with no result and no timeout pulse.
- `done_q` samples `Done` every cycle. A completion event is `Done`=1 and `done_q`=0 (rising edge). A level held over from an earlier job is never accepted.
- State `IDLE`:
  - `Start`=1 latches `OpA` and `OpB`, loads the hold counter with `HOLD_CYCLES`-1, and moves to `DRIVE_A`.
  - `Start`=0 stays in `IDLE`; `Inport` keeps its last value.
- State `DRIVE_A`:
  - `Inport`=latched A for exactly `HOLD_CYCLES` cycles.
  - When the counter reaches 0: reload the counter and move to `DRIVE_B`.
- State `DRIVE_B`:
  - `Inport`=latched B for exactly `HOLD_CYCLES` cycles.
  - When the counter reaches 0: clear the timeout counter and move to `WAIT_DONE`.
- State `WAIT_DONE`:
  - `Inport` holds B.
  - On a completion event: `Result`<=`Outport` sampled on that same edge, `ResultValid`=1 for the following cycle, next state `IDLE`.
  - Otherwise the timeout counter increments. When it reaches `TIMEOUT_CYCLES`-1 with no event: `TimedOut`=1 for the following cycle, `Result` unchanged, next state `IDLE`.
  - If a completion event and the timeout terminal count occur in the same cycle, completion wins (`ResultValid` asserted, `TimedOut` not asserted).
- Latency, with `Start` sampled on edge 0:
  - A visible on `Inport` in cycles 1..`HOLD_CYCLES`.
  - B visible in cycles `HOLD_CYCLES`+1..2·`HOLD_CYCLES`.
  - `WAIT_DONE` begins at cycle 2·`HOLD_CYCLES`+1.
  - Result appears one cycle after the `Done` edge is sampled.
- `Start` while `Busy`=1 is ignored; it is neither queued nor does it alter the latched operands.
- `Start` in the same cycle that `ResultValid` or `TimedOut` is high is accepted, because the state is already `IDLE`. Back-to-back jobs are allowed.
- `Busy` drops to 0 in the same cycle that `ResultValid` or `TimedOut` is high.
- Counters are sized to `clog2` of their parameter. Wrap-around never occurs, because both counters are reloaded or cleared on each state entry.

Test Plan:
- Reset with `Done` held at 1, then `Start` with `OpA`=16'h0003, `OpB`=16'h0005 → no false completion. `Inport`=3 for cycles 1-4 and 5 for cycles 5-8; `Busy`=1 from cycle 1.
- Same job, ASIC model raises `Done` at cycle 12 with `Outport`=16'h0008 → `Result`=16'h0008 and `ResultValid`=1 for one cycle at cycle 13; `Busy`=0 at cycle 13.
- `Done` never rises, `TIMEOUT_CYCLES`=64 → `TimedOut` pulses once 64 cycles after `WAIT_DONE` entry; `Result` keeps its previous value.
- `Start` pulsed at cycles 2 and 6 during a job with `OpA`=16'hFFFF → ignored; `Inport` still shows the original operands.
- New `Start` in the `ResultValid` cycle → second job begins with no idle gap and both results are correct in order.
- `RST_N`=0 for one cycle during `DRIVE_B` → next cycle shows state `IDLE`, `Inport`=0, no `ResultValid` and no `TimedOut`.
